block_pass_sequencer: RTL and testbench
=======================================

# block_pass_sequencer

Per-sample controller for the block fetch/decode pipeline. On each `sample_tick` it admits exactly `n_active` decoded instructions (one per running block) into the execute stage and waits for all of them to retire. It then reports pass completion. Between passes it accepts new block-count configurations, flushing the fetch/decode pipeline so that no stale instructions issue. It sits between the fetch/decode stage output and the execute stage, and drives the fetcher's `n_blocks_running` and `enable`.

## Interface
Parameters:
- `n_blocks`, 256, maximum block count; `NB = $clog2(n_blocks)`.
- `flush_cycles`, 4, cycles spent in SWAP (minimum 2).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `sample_tick`  in  1  single-cycle pulse, start of a sample period
- `cfg_valid`  in  1  new block-count request
- `cfg_ready`  out  1  request accepted when `cfg_valid & cfg_ready`
- `cfg_n_blocks`  in  NB  requested block count
- `n_blocks_running`  out  NB  to fetcher
- `fetch_enable`  out  1  to fetch/decode `enable`
- `pipe_flush`  out  1  synchronous clear for the fetch/decode stages
- `up_valid`  in  1  decode stage `out_valid`
- `up_ready`  out  1  to decode stage `out_ready`
- `dn_valid`  out  1  to execute stage
- `dn_ready`  in  1  from execute stage
- `retire`  in  1  one pulse per retired instruction
- `pass_done`  out  1  single-cycle pulse, pass complete
- `pass_cycles`  out  16  cycles taken by the last pass, saturating
- `overrun_count`  out  8  ticks dropped, saturating at 255

## Operation
- States: IDLE, RUN, DRAIN, SWAP.
- Registers:
  - `n_active` (NB bits): drives `n_blocks_running`.
  - `issue_cnt`, `retire_cnt` (NB+1 bits each).
  - `cyc_cnt` (16 bits).
- Gating: `allow = (state == RUN)`; `dn_valid = up_valid & allow`; `up_ready = dn_ready & allow`. A "fire" is `dn_valid & dn_ready`.
- `fetch_enable = (state != SWAP)`. `pipe_flush = (state == SWAP)`.
- IDLE transitions:
  - `sample_tick` with `n_active > 0`: clear `issue_cnt`, `retire_cnt`, `cyc_cnt`; go to RUN.
  - `sample_tick` with `n_active == 0`: `pass_done` pulses next cycle, `pass_cycles` ← 0, stay in IDLE.
  - Otherwise, if `cfg_valid`: go to SWAP and latch `cfg_n_blocks` into a pending register.
  - `cfg_ready = (state == IDLE) & ~sample_tick`. A tick has priority over configuration in the same cycle.
- RUN:
  - Each fire increments `issue_cnt`.
  - When a fire brings `issue_cnt` to `n_active`, go to DRAIN. `allow` is 0 from the next cycle.
- DRAIN: when `retire_cnt == n_active`, go to IDLE. On that transition, pulse `pass_done` and set `pass_cycles` ← `cyc_cnt`.
- Retires: `retire` increments `retire_cnt` in RUN and DRAIN. A retire in RUN counts toward the pass. `retire` in IDLE or SWAP is ignored.
- Cycle counting: `cyc_cnt` increments each cycle in RUN and DRAIN, saturating at 0xFFFF.
- SWAP:
  - `n_blocks_running` is forced to 0 for all `flush_cycles` cycles. This resets the fetcher read address; the buffer and decoder are cleared via `pipe_flush`.
  - On the last cycle, `n_active` ← pending value, then go to IDLE.
- Overrun: `sample_tick` in any state other than IDLE is dropped and increments `overrun_count` (saturating). This includes IDLE→RUN entry already in progress.
- Pass-stage instructions beyond `n_active` remain stalled in the pipeline (backpressure) and issue first in the next pass. Fetch order is cyclic, so block order is preserved across passes.

## Timing
- Reset values:
  - state IDLE; `n_blocks_running` 0; `n_active` 0.
  - `fetch_enable` 1; `pipe_flush` 0.
  - `dn_valid` 0; `up_ready` 0; `cfg_ready` 1.
  - `pass_done` 0; `pass_cycles` 0; `overrun_count` 0; all counters 0.
- Reset mid-pass or mid-SWAP aborts immediately. The configuration is lost (`n_active` = 0) and the host must reconfigure.
- Pass start: tick at cycle T (IDLE) → state RUN at T+1; first fire possible at T+1.
- Pass end: retire completing the count at cycle R → state IDLE and `pass_done` high at R+1.
- Zero-block tick at T → `pass_done` high at T+1.
- Configuration: accepted at T → SWAP during T+1 … T+`flush_cycles`. `n_blocks_running` = new value and state IDLE at T+`flush_cycles`+1. A tick arriving in SWAP counts as an overrun.
- `dn_valid`/`up_ready` are combinational from registered state plus `up_valid`/`dn_ready`. There is no extra latency on the data path; data wires bypass the block.

## Test plan
- Reset, then configure 3 blocks: `cfg_ready` high; `n_blocks_running` = 0 for 4 cycles, then 3; `pipe_flush` high exactly 4 cycles.
- `n_active` = 3, tick, downstream always ready, retire each fire 2 cycles later: exactly 3 fires; `up_ready` low after the 3rd; `pass_done` one cycle after the 3rd retire; `pass_cycles` = 5.
- `n_active` = 3, `dn_ready` held low 10 cycles mid-pass: fire count still 3; `pass_cycles` grows by 10.
- Tick during DRAIN, then 300 ticks during RUN: `overrun_count` = 1, then saturates at 255; passes complete normally.
- Tick and `cfg_valid` in the same IDLE cycle: `cfg_ready` = 0, pass starts; config accepted only in the first IDLE cycle after `pass_done`.
- `n_active` = 0, tick: `pass_done` next cycle, `pass_cycles` = 0, no fires; reset asserted mid-RUN: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/block_pass_sequencer.sv
// Per-sample pass controller between fetch/decode and execute.
// Admits n_active instructions per tick, waits for retirement, swaps configs.
module block_pass_sequencer #(
    parameter int n_blocks     = 256,
    parameter int flush_cycles = 4,
    localparam int NB          = $clog2(n_blocks)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_tick,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [NB-1:0] cfg_n_blocks,
    output logic [NB-1:0] n_blocks_running,
    output logic          fetch_enable,
    output logic          pipe_flush,
    input  logic          up_valid,
    output logic          up_ready,
    output logic          dn_valid,
    input  logic          dn_ready,
    input  logic          retire,
    output logic          pass_done,
    output logic [15:0]   pass_cycles,
    output logic [7:0]    overrun_count
);

    localparam int FW = $clog2(flush_cycles + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;

    state_t        state_q;
    logic [NB-1:0] n_active_q;
    logic [NB-1:0] pending_q;
    logic [NB:0]   issue_cnt_q;
    logic [NB:0]   retire_cnt_q;
    logic [15:0]   cyc_cnt_q;
    logic [FW-1:0] flush_cnt_q;
    logic          pass_done_q;
    logic [15:0]   pass_cycles_q;
    logic [7:0]    overrun_q;

    logic          allow;
    logic          fire;
    logic [NB:0]   issue_cnt_d;
    logic [NB:0]   retire_cnt_d;
    logic [NB:0]   n_active_x;
    logic [15:0]   cyc_cnt_d;

    assign allow        = (state_q == RUN);
    assign dn_valid     = up_valid & allow;
    assign up_ready     = dn_ready & allow;
    assign fire         = dn_valid & dn_ready;
    assign fetch_enable = (state_q != SWAP);
    assign pipe_flush   = (state_q == SWAP);
    assign cfg_ready    = (state_q == IDLE) & ~sample_tick;

    // Zero during SWAP rewinds the fetcher read address.
    assign n_blocks_running = (state_q == SWAP) ? '0 : n_active_q;

    assign pass_done     = pass_done_q;
    assign pass_cycles   = pass_cycles_q;
    assign overrun_count = overrun_q;

    assign n_active_x   = {1'b0, n_active_q};
    assign issue_cnt_d  = issue_cnt_q + {{NB{1'b0}}, fire};
    assign retire_cnt_d = retire_cnt_q + {{NB{1'b0}}, retire};
    assign cyc_cnt_d    = (cyc_cnt_q == 16'hFFFF) ? cyc_cnt_q
                                                  : cyc_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            n_active_q    <= '0;
            pending_q     <= '0;
            issue_cnt_q   <= '0;
            retire_cnt_q  <= '0;
            cyc_cnt_q     <= '0;
            flush_cnt_q   <= '0;
            pass_done_q   <= 1'b0;
            pass_cycles_q <= '0;
            overrun_q     <= '0;
        end else begin
            pass_done_q <= 1'b0;
            if (sample_tick && state_q != IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;
            unique case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        if (n_active_q != '0) begin
                            issue_cnt_q  <= '0;
                            retire_cnt_q <= '0;
                            cyc_cnt_q    <= '0;
                            state_q      <= RUN;
                        end else begin
                            pass_done_q   <= 1'b1;
                            pass_cycles_q <= '0;
                        end
                    end else if (cfg_valid) begin
                        pending_q   <= cfg_n_blocks;
                        flush_cnt_q <= '0;
                        state_q     <= SWAP;
                    end
                end
                RUN: begin
                    issue_cnt_q  <= issue_cnt_d;
                    retire_cnt_q <= retire_cnt_d;
                    cyc_cnt_q    <= cyc_cnt_d;
                    if (fire && issue_cnt_d == n_active_x)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    retire_cnt_q <= retire_cnt_d;
                    cyc_cnt_q    <= cyc_cnt_d;
                    // Reported count includes the completing cycle.
                    if (retire_cnt_d >= n_active_x) begin
                        pass_done_q   <= 1'b1;
                        pass_cycles_q <= cyc_cnt_d;
                        state_q       <= IDLE;
                    end
                end
                SWAP: begin
                    flush_cnt_q <= flush_cnt_q + FW'(1);
                    if (flush_cnt_q == FW'(flush_cycles - 1)) begin
                        n_active_q <= pending_q;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_pass_sequencer.sv
// Directed bench for block_pass_sequencer: config swap, passes,
// stalls, overruns, tick/config priority, zero blocks, reset.
module tb_block_pass_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_n_blocks = 8'd0;
    logic [7:0]  n_blocks_running;
    logic        fetch_enable;
    logic        pipe_flush;
    logic        up_valid = 1'b1;
    logic        up_ready;
    logic        dn_valid;
    logic        dn_ready = 1'b1;
    logic        retire = 1'b0;
    logic        pass_done;
    logic [15:0] pass_cycles;
    logic [7:0]  overrun_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    block_pass_sequencer #(.n_blocks(256), .flush_cycles(4)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n_blocks(cfg_n_blocks), .n_blocks_running(n_blocks_running),
        .fetch_enable(fetch_enable), .pipe_flush(pipe_flush),
        .up_valid(up_valid), .up_ready(up_ready),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .retire(retire),
        .pass_done(pass_done), .pass_cycles(pass_cycles),
        .overrun_count(overrun_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Executes a pass: retire follows each fire by 2 cycles.
    task automatic run_pass(input bit tick0, input int st, input int sl,
                            output int fires, output int done_c,
                            output int late_ready, output int cfg_seen);
        int hist[0:255];
        fires = 0; done_c = -1; late_ready = 0; cfg_seen = 0;
        for (int c = 0; c < 200; c++) begin
            sample_tick = tick0 && (c == 0);
            dn_ready = !(c >= st && c < st + sl);
            retire = (c >= 2) && (hist[c-2] != 0);
            #1;
            hist[c] = (dn_valid && dn_ready) ? 1 : 0;
            if (fires >= 3 && up_ready) late_ready++;
            if (cfg_ready) cfg_seen++;
            fires += hist[c];
            if (pass_done) begin
                done_c = c;
                break;
            end
            step();
        end
        sample_tick = 1'b0;
        retire = 1'b0;
        dn_ready = 1'b1;
    endtask

    task automatic configure(input logic [7:0] n);
        int fl;
        fl = 0;
        cfg_valid = 1'b1;
        cfg_n_blocks = n;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_ready_idle got %b want 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (n_blocks_running !== 8'd0 || pipe_flush !== 1'b1
                || fetch_enable !== 1'b0) begin
                n_err++;
                $display("FAIL swap_cycle%0d nbr=%0d flush=%b fen=%b want 0/1/0",
                         i, n_blocks_running, pipe_flush, fetch_enable);
            end
            step();
        end
        n_vec++;
        if (n_blocks_running !== n || pipe_flush !== 1'b0
            || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL swap_end nbr=%0d flush=%b rdy=%b want %0d/0/1",
                     n_blocks_running, pipe_flush, cfg_ready, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_vec++;
        if (n_blocks_running !== 8'd0 || fetch_enable !== 1'b1
            || pipe_flush !== 1'b0 || dn_valid !== 1'b0
            || up_ready !== 1'b0 || cfg_ready !== 1'b1
            || pass_done !== 1'b0 || pass_cycles !== 16'd0
            || overrun_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state nbr=%0d fen=%b fl=%b dv=%b ur=%b cr=%b pd=%b pc=%0d ov=%0d",
                     n_blocks_running, fetch_enable, pipe_flush, dn_valid,
                     up_ready, cfg_ready, pass_done, pass_cycles,
                     overrun_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_config();
        configure(8'd3);
    endtask

    task automatic test_basic_pass();
        int f, d, lr, cs;
        run_pass(1'b1, 0, 0, f, d, lr, cs);
        n_vec++;
        if (f !== 3) begin
            n_err++; $display("FAIL basic_fires got %0d want 3", f);
        end
        n_vec++;
        if (d !== 6) begin
            n_err++; $display("FAIL basic_done_cycle got %0d want 6", d);
        end
        n_vec++;
        if (lr !== 0) begin
            n_err++; $display("FAIL basic_up_ready_late got %0d want 0", lr);
        end
        n_vec++;
        if (pass_cycles !== 16'd5) begin
            n_err++; $display("FAIL basic_pass_cycles got %0d want 5", pass_cycles);
        end
        step();
        n_vec++;
        if (pass_done !== 1'b0) begin
            n_err++; $display("FAIL basic_done_pulse got %b want 0", pass_done);
        end
    endtask

    task automatic test_stall();
        int f, d, lr, cs;
        run_pass(1'b1, 2, 10, f, d, lr, cs);
        n_vec++;
        if (f !== 3) begin
            n_err++; $display("FAIL stall_fires got %0d want 3", f);
        end
        n_vec++;
        if (d !== 16) begin
            n_err++; $display("FAIL stall_done_cycle got %0d want 16", d);
        end
        n_vec++;
        if (pass_cycles !== 16'd15) begin
            n_err++; $display("FAIL stall_pass_cycles got %0d want 15", pass_cycles);
        end
        step();
    endtask

    task automatic test_overrun();
        int f, d, lr, cs;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (4) step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n_vec++;
        if (overrun_count !== 8'd1) begin
            n_err++; $display("FAIL overrun_drain got %0d want 1", overrun_count);
        end
        retire = 1'b1;
        repeat (3) step();
        retire = 1'b0;
        n_vec++;
        if (pass_done !== 1'b1 || pass_cycles !== 16'd8) begin
            n_err++;
            $display("FAIL overrun_pass1 done=%b cyc=%0d want 1/8",
                     pass_done, pass_cycles);
        end
        sample_tick = 1'b1;
        dn_ready = 1'b0;
        step();
        for (int i = 0; i < 300; i++) begin
            sample_tick = 1'b1;
            step();
            if (i == 9) begin
                n_vec++;
                if (overrun_count !== 8'd11) begin
                    n_err++;
                    $display("FAIL overrun_count_mid got %0d want 11", overrun_count);
                end
            end
        end
        sample_tick = 1'b0;
        n_vec++;
        if (overrun_count !== 8'd255) begin
            n_err++; $display("FAIL overrun_sat got %0d want 255", overrun_count);
        end
        run_pass(1'b0, 0, 0, f, d, lr, cs);
        n_vec++;
        if (f !== 3 || d !== 5) begin
            n_err++;
            $display("FAIL overrun_pass2 fires=%0d done=%0d want 3/5", f, d);
        end
        n_vec++;
        if (overrun_count !== 8'd255) begin
            n_err++; $display("FAIL overrun_hold got %0d want 255", overrun_count);
        end
        step();
    endtask

    task automatic test_tick_cfg();
        int f, d, lr, cs;
        sample_tick = 1'b1;
        cfg_valid = 1'b1;
        cfg_n_blocks = 8'd5;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
            n_err++; $display("FAIL tickcfg_ready got %b want 0", cfg_ready);
        end
        run_pass(1'b1, 0, 0, f, d, lr, cs);
        n_vec++;
        if (f !== 3 || d !== 6) begin
            n_err++;
            $display("FAIL tickcfg_pass fires=%0d done=%0d want 3/6", f, d);
        end
        n_vec++;
        if (cs !== 1 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tickcfg_accept_cycles got %0d rdy=%b want 1/1",
                     cs, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        n_vec++;
        if (pipe_flush !== 1'b1 || n_blocks_running !== 8'd0) begin
            n_err++;
            $display("FAIL tickcfg_swap flush=%b nbr=%0d want 1/0",
                     pipe_flush, n_blocks_running);
        end
        repeat (4) step();
        n_vec++;
        if (n_blocks_running !== 8'd5 || pipe_flush !== 1'b0) begin
            n_err++;
            $display("FAIL tickcfg_new nbr=%0d flush=%b want 5/0",
                     n_blocks_running, pipe_flush);
        end
    endtask

    task automatic test_zero();
        configure(8'd0);
        sample_tick = 1'b1;
        #1;
        n_vec++;
        if (dn_valid !== 1'b0) begin
            n_err++; $display("FAIL zero_dn_valid got %b want 0", dn_valid);
        end
        step();
        sample_tick = 1'b0;
        n_vec++;
        if (pass_done !== 1'b1 || pass_cycles !== 16'd0
            || dn_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done done=%b cyc=%0d dv=%b want 1/0/0",
                     pass_done, pass_cycles, dn_valid);
        end
        step();
        n_vec++;
        if (pass_done !== 1'b0) begin
            n_err++; $display("FAIL zero_pulse got %b want 0", pass_done);
        end
    endtask

    task automatic test_reset_mid();
        configure(8'd3);
        sample_tick = 1'b1;
        dn_ready = 1'b0;
        step();
        sample_tick = 1'b0;
        step();
        n_vec++;
        if (dn_valid !== 1'b1) begin
            n_err++; $display("FAIL midrun_dn_valid got %b want 1", dn_valid);
        end
        dn_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_vec++;
        if (n_blocks_running !== 8'd0 || fetch_enable !== 1'b1
            || pipe_flush !== 1'b0 || dn_valid !== 1'b0
            || up_ready !== 1'b0 || cfg_ready !== 1'b1
            || pass_done !== 1'b0 || pass_cycles !== 16'd0
            || overrun_count !== 8'd0) begin
            n_err++;
            $display("FAIL midrun_reset nbr=%0d fen=%b fl=%b dv=%b ur=%b cr=%b pd=%b pc=%0d ov=%0d",
                     n_blocks_running, fetch_enable, pipe_flush, dn_valid,
                     up_ready, cfg_ready, pass_done, pass_cycles,
                     overrun_count);
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n_vec++;
        if (pass_done !== 1'b1) begin
            n_err++; $display("FAIL postreset_zero_pass got %b want 1", pass_done);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_basic_pass();
        test_stall();
        test_overrun();
        test_tick_cfg();
        test_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
